axi4lite_clint_mh: RTL
======================

Name: axi4lite_clint_mh

Overview:
Multi-hart AXI4-Lite core-local interruptor, the parametrised successor of the single-counter timer slave. It provides:
- a 64-bit prescaled mtime;
- one 64-bit mtimecmp per hart;
- one msip bit per hart.

It drives registered per-hart machine timer (mtip) and software (msip) interrupt lines into the cores. It sits on the MMIO crossbar beside the UART and other peripherals.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width; only 32 supported
BASE_ADDR, 32'ha000_0000, device base address
NUM_HARTS, 2, number of harts, 1..8
TICK_DIV, 1, mtime increments once every TICK_DIV clocks, 1..65535

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
arvalid  in  1  read address valid
araddr  in  ADDR_WIDTH  read address
arready  out  1  read address ready
rvalid  out  1  read data valid
rdata  out  DATA_WIDTH  read data
rresp  out  2  read response
rready  in  1  read data ready
awvalid  in  1  write address valid
awaddr  in  ADDR_WIDTH  write address
awready  out  1  write address ready
wvalid  in  1  write data valid
wdata  in  DATA_WIDTH  write data
wstrb  in  4  byte strobes
wready  out  1  write data ready
bvalid  out  1  write response valid
bresp  out  2  write response
bready  in  1  write response ready
mtip  out  NUM_HARTS  timer interrupt per hart
msip  out  NUM_HARTS  software interrupt per hart

Behaviour:
- Reset (clk edge with rst=1) sets the following values:
  - mtime=0, prescaler=0, mtimecmp[h]=64'hFFFF_FFFF_FFFF_FFFF, msip=0, mtip=0;
  - rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0;
  - aw/w holding flags cleared.
- Reset mid-transaction drops the transaction silently; no response is issued.
- Register map, offsets from BASE_ADDR, all 32-bit words:
  - 0x0048 mtime[31:0]; 0x004C mtime[63:32]. These offsets are unchanged from the previous generation.
  - 0x1000+4h msip[h]. Only bit0 is writable; bits 31:1 read 0.
  - 0x2000+8h mtimecmp[h][31:0]; 0x2004+8h mtimecmp[h][63:32].
- Decode errors:
  - An address outside the map, an address with addr[1:0]!=0, or a hart index >= NUM_HARTS gives resp=2'b10 (SLVERR).
  - Reads with an error return rdata=0.
  - Writes with an error have no effect.
  - OKAY is 2'b00.
- Prescaler:
  - The counter runs 0..TICK_DIV-1. mtime+1 happens on the edge where the counter equals TICK_DIV-1, and the counter then wraps to 0.
  - TICK_DIV=1 means mtime increments every cycle.
  - mtime wraps from 2^64-1 to 0.
- Read channel:
  - arready = ~rvalid.
  - On an AR handshake edge, rdata/rresp capture the register value present before that edge, and rvalid<=1.
  - Read latency is 1 cycle.
  - rvalid and rdata hold until rready; rvalid clears on the rvalid&rready edge.
  - Back-to-back reads are not allowed: one read is outstanding at most.
- Write channel:
  - awready = ~aw_held and wready = ~w_held. AW and W are accepted independently, in any order or in the same cycle, into holding registers.
  - Commit happens on the first edge where aw_held & w_held & ~bvalid.
  - Commit does the following: applies a byte-merge of wdata under wstrb into the target word, sets bvalid=1 with bresp, and clears both held flags.
  - Commit latency is one cycle after the later of the two handshakes.
  - While bvalid is high, a pending held pair waits.
- Simultaneous events:
  - A commit to mtime lo or hi in the same cycle as a tick: the written half takes wdata, the other half is unchanged, and the increment is dropped for that cycle.
  - The prescaler is never reset by writes.
  - A read and a commit on the same edge to the same register: the read returns the old value.
- Interrupts:
  - mtip[h] is registered: mtip[h] <= (mtime >= mtimecmp[h]), unsigned 64-bit compare using the current register values.
  - It therefore lags the register change by 1 cycle.
  - It is level, and is cleared only by raising mtimecmp or lowering mtime.
  - msip[h] output equals the register bit directly.
- Writing mtimecmp as two halves can transiently assert mtip; this is accepted software-visible behaviour.

Test Plan:
- Reset, then read 0xA000_0048 after 10 idle cycles (TICK_DIV=1) -> rvalid 1 cycle after AR, rdata = mtime sampled at the AR edge (≈10), rresp=0.
- TICK_DIV=4: sample mtime twice 40 cycles apart -> difference 10 ±1; set mtime hi 0xFFFF_FFFF, lo 0xFFFF_FFFE -> mtime wraps to 0 within 8 cycles.
- Write mtimecmp[1]=mtime+20 (hi first, then lo) -> mtip[1] rises 1 cycle after mtime reaches that value, mtip[0] stays 0; rewrite hi to 0xFFFF_FFFF -> mtip[1] falls next cycle.
- Write msip[0] with wdata=0xFFFF_FFFF, wstrb=4'b0001 -> msip[0]=1; readback = 0x1; wstrb=4'b0010 write of 0 -> msip unchanged.
- AW presented 3 cycles before W, with bready held low 5 cycles -> awready low until commit, bvalid stays high; a second AW/W pair is accepted and commits only after the first B handshake.
- Read 0xA000_0044, write 0xA000_2010 with NUM_HARTS=2, read 0xA000_004A -> SLVERR, rdata=0, no register change.

Source files
------------

// File: rtl/axi4lite_clint_mh.sv
// Multi-hart AXI4-Lite CLINT: prescaled 64-bit mtime, per-hart mtimecmp and msip,
// registered per-hart timer interrupt lines.
module axi4lite_clint_mh #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'hA000_0000,
  parameter int unsigned           NUM_HARTS  = 2,
  parameter int unsigned           TICK_DIV   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  arvalid_i,
  input  logic [ADDR_WIDTH-1:0] araddr_i,
  output logic                  arready_o,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [1:0]            rresp_o,
  input  logic                  rready_i,
  input  logic                  awvalid_i,
  input  logic [ADDR_WIDTH-1:0] awaddr_i,
  output logic                  awready_o,
  input  logic                  wvalid_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [3:0]            wstrb_i,
  output logic                  wready_o,
  output logic                  bvalid_o,
  output logic [1:0]            bresp_o,
  input  logic                  bready_i,
  output logic [NUM_HARTS-1:0]  mtip_o,
  output logic [NUM_HARTS-1:0]  msip_o
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [2:0] {
    SelNone,
    SelMtimeLo,
    SelMtimeHi,
    SelMsip,
    SelCmpLo,
    SelCmpHi
  } sel_e;

  typedef struct packed {
    sel_e       sel;
    logic [2:0] hart;
  } dec_t;

  // Maps a bus address to a register; SelNone covers every SLVERR case.
  function automatic dec_t decode(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    dec_t                  d;
    off    = addr - BASE_ADDR;
    d.sel  = SelNone;
    d.hart = '0;
    if (addr[1:0] == 2'b00) begin
      if (off == ADDR_WIDTH'(32'h48)) begin
        d.sel = SelMtimeLo;
      end else if (off == ADDR_WIDTH'(32'h4C)) begin
        d.sel = SelMtimeHi;
      end else if ((off & ~ADDR_WIDTH'(32'h1F)) == ADDR_WIDTH'(32'h1000)) begin
        if (32'(off[4:2]) < NUM_HARTS) begin
          d.sel  = SelMsip;
          d.hart = off[4:2];
        end
      end else if ((off & ~ADDR_WIDTH'(32'h3F)) == ADDR_WIDTH'(32'h2000)) begin
        if (32'(off[5:3]) < NUM_HARTS) begin
          d.sel  = off[2] ? SelCmpHi : SelCmpLo;
          d.hart = off[5:3];
        end
      end
    end
    return d;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

  // Architectural state
  logic [15:0]                 presc_q, presc_d;
  logic [63:0]                 mtime_q, mtime_d;
  logic [NUM_HARTS-1:0][63:0]  mtimecmp_q, mtimecmp_d;
  logic [NUM_HARTS-1:0]        msip_q, msip_d;
  logic [NUM_HARTS-1:0]        mtip_q, mtip_d;

  // Read channel
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  // Write channel holding registers
  logic                  aw_held_q, aw_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                  w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;

  logic        tick, commit, ar_hs, aw_hs, w_hs;
  dec_t        rd_dec, wr_dec;
  logic [31:0] rd_val, msip_word;

  assign arready_o = ~rvalid_q;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;
  assign awready_o = ~aw_held_q;
  assign wready_o  = ~w_held_q;
  assign bvalid_o  = bvalid_q;
  assign bresp_o   = bresp_q;
  assign mtip_o    = mtip_q;
  assign msip_o    = msip_q;

  assign ar_hs  = arvalid_i & ~rvalid_q;
  assign aw_hs  = awvalid_i & ~aw_held_q;
  assign w_hs   = wvalid_i & ~w_held_q;
  assign commit = aw_held_q & w_held_q & ~bvalid_q;
  assign tick   = (presc_q == 16'(TICK_DIV - 1));

  // Read data is taken from the current registers, so a same-edge commit is not visible.
  always_comb begin
    rd_dec = decode(araddr_i);
    rd_val = '0;
    case (rd_dec.sel)
      SelMtimeLo: rd_val = mtime_q[31:0];
      SelMtimeHi: rd_val = mtime_q[63:32];
      SelMsip: begin
        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
          if (rd_dec.hart == 3'(h)) rd_val = {31'b0, msip_q[h]};
        end
      end
      SelCmpLo: begin
        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
          if (rd_dec.hart == 3'(h)) rd_val = mtimecmp_q[h][31:0];
        end
      end
      SelCmpHi: begin
        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
          if (rd_dec.hart == 3'(h)) rd_val = mtimecmp_q[h][63:32];
        end
      end
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val;
      rresp_d  = (rd_dec.sel == SelNone) ? RespSlverr : RespOkay;
    end else if (rvalid_q && rready_i) begin
      rvalid_d = 1'b0;
    end
  end

  always_comb begin
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    wr_dec    = decode(awaddr_q);
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = awaddr_i;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = wdata_i;
      wstrb_d  = wstrb_i;
    end
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = (wr_dec.sel == SelNone) ? RespSlverr : RespOkay;
    end else if (bvalid_q && bready_i) begin
      bvalid_d = 1'b0;
    end
  end

  // A committed mtime write overrides that cycle's increment; the prescaler keeps running.
  always_comb begin
    presc_d    = tick ? 16'd0 : presc_q + 16'd1;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    msip_word  = '0;
    if (commit) begin
      case (wr_dec.sel)
        SelMtimeLo: mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], wdata_q, wstrb_q)};
        SelMtimeHi: mtime_d = {merge(mtime_q[63:32], wdata_q, wstrb_q), mtime_q[31:0]};
        SelMsip: begin
          for (int unsigned h = 0; h < NUM_HARTS; h++) begin
            if (wr_dec.hart == 3'(h)) begin
              msip_word = merge({31'b0, msip_q[h]}, wdata_q, wstrb_q);
              msip_d[h] = msip_word[0];
            end
          end
        end
        SelCmpLo: begin
          for (int unsigned h = 0; h < NUM_HARTS; h++) begin
            if (wr_dec.hart == 3'(h)) begin
              mtimecmp_d[h][31:0] = merge(mtimecmp_q[h][31:0], wdata_q, wstrb_q);
            end
          end
        end
        SelCmpHi: begin
          for (int unsigned h = 0; h < NUM_HARTS; h++) begin
            if (wr_dec.hart == 3'(h)) begin
              mtimecmp_d[h][63:32] = merge(mtimecmp_q[h][63:32], wdata_q, wstrb_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mtip_d = '0;
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      mtip_d[h] = (mtime_q >= mtimecmp_q[h]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= '0;
      mtip_q     <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RespOkay;
      aw_held_q  <= 1'b0;
      awaddr_q   <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RespOkay;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      mtip_q     <= mtip_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      aw_held_q  <= aw_held_d;
      awaddr_q   <= awaddr_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
    end
  end

endmodule
